// File: rtl/demux_stream_generic_if.sv
// Stream bundle for demux_stream_generic: one input stream, CHANNELS_COUNT output streams
// and the drop statistics. The demux takes the slave side; the producer/consumers take master.
interface demux_stream_generic_if #(
  parameter int unsigned CHANNELS_COUNT   = 4,
  parameter int unsigned CHANNELS_WIDTH   = 8,
  parameter int unsigned DROP_COUNT_WIDTH = 16
);

  localparam int unsigned SelWidth = (CHANNELS_COUNT > 1) ? $clog2(CHANNELS_COUNT) : 1;

  // Input stream
  logic                                           in_valid;
  logic                                           in_ready;
  logic [SelWidth-1:0]                            in_select;
  logic [CHANNELS_WIDTH-1:0]                      in_data;

  // Output streams, bit/slot i belongs to channel i
  logic [CHANNELS_COUNT-1:0]                      out_valid;
  logic [CHANNELS_COUNT-1:0]                      out_ready;
  logic [CHANNELS_COUNT-1:0][CHANNELS_WIDTH-1:0]  out_channels;

  // Discard statistics
  logic                                           drop_pulse;
  logic [DROP_COUNT_WIDTH-1:0]                    drop_count;

  // Demux side
  modport slave (
    input  in_valid,
    input  in_select,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_channels,
    output drop_pulse,
    output drop_count
  );

  // Producer / consumer side
  modport master (
    output in_valid,
    output in_select,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_channels,
    input  drop_pulse,
    input  drop_count
  );

endinterface

// File: rtl/demux_stream_generic.sv
// Valid/ready stream demultiplexer. Each beat is steered to the channel named by in_select and
// held in a one-entry per-channel buffer, so a stalled channel only blocks beats addressed to it.
// Out-of-range selects are accepted, discarded, pulsed on drop_pulse and counted (saturating).
module demux_stream_generic #(
  parameter int unsigned CHANNELS_COUNT   = 4,
  parameter int unsigned CHANNELS_WIDTH   = 8,
  parameter int unsigned DROP_COUNT_WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  demux_stream_generic_if.slave bus_io
);

  // Elaboration-time parameter sanity
  if (CHANNELS_COUNT < 2) begin : g_bad_count
    $fatal(1, "demux_stream_generic: CHANNELS_COUNT must be >= 2");
  end
  if (CHANNELS_WIDTH < 1) begin : g_bad_width
    $fatal(1, "demux_stream_generic: CHANNELS_WIDTH must be >= 1");
  end
  if (DROP_COUNT_WIDTH < 1) begin : g_bad_drop_width
    $fatal(1, "demux_stream_generic: DROP_COUNT_WIDTH must be >= 1");
  end

  // Per-channel buffers
  logic [CHANNELS_COUNT-1:0]                     valid_q, valid_d;
  logic [CHANNELS_COUNT-1:0][CHANNELS_WIDTH-1:0] data_q, data_d;

  // Drop statistics
  logic                        drop_pulse_q, drop_pulse_d;
  logic [DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

  // Select decode and handshake
  logic                      sel_in_range;
  logic [CHANNELS_COUNT-1:0] sel_onehot;
  logic                      chan_free;
  logic                      in_ready;
  logic                      accept;
  logic [CHANNELS_COUNT-1:0] load;
  logic [CHANNELS_COUNT-1:0] drain;

  // Decode in_select; the unsigned compare matters when CHANNELS_COUNT is not a power of two
  always_comb begin
    sel_in_range = 32'(bus_io.in_select) < CHANNELS_COUNT;
    sel_onehot   = '0;
    for (int unsigned i = 0; i < CHANNELS_COUNT; i++) begin
      sel_onehot[i] = (32'(bus_io.in_select) == i);
    end
  end

  // Ready looks only at the addressed channel; a discard always has room
  always_comb begin
    chan_free = |(sel_onehot & (~valid_q | bus_io.out_ready));
    in_ready  = !rst && (!sel_in_range || chan_free);
    accept    = bus_io.in_valid && in_ready;
  end

  // Buffer next state: a load wins over a drain so a channel streams one beat per cycle
  always_comb begin
    load    = '0;
    drain   = '0;
    valid_d = valid_q;
    data_d  = data_q;
    for (int unsigned i = 0; i < CHANNELS_COUNT; i++) begin
      load[i]    = accept && sel_onehot[i];
      drain[i]   = valid_q[i] && bus_io.out_ready[i];
      valid_d[i] = load[i] || (valid_q[i] && !bus_io.out_ready[i]);
      if (load[i]) begin
        data_d[i] = bus_io.in_data;
      end else if (drain[i]) begin
        // Idle channels present zero data
        data_d[i] = '0;
      end
    end
  end

  // Drop pulse and saturating counter next state
  always_comb begin
    drop_pulse_d = accept && !sel_in_range;
    drop_count_d = drop_count_q;
    if (drop_pulse_d && (drop_count_q != {DROP_COUNT_WIDTH{1'b1}})) begin
      drop_count_d = drop_count_q + 1'b1;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      data_q       <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign bus_io.in_ready     = in_ready;
  assign bus_io.out_valid    = valid_q;
  assign bus_io.out_channels = data_q;
  assign bus_io.drop_pulse   = drop_pulse_q;
  assign bus_io.drop_count   = drop_count_q;

endmodule

// File: tb/tb_demux_stream_generic.sv
// Bench for demux_stream_generic: a 4-channel/16-bit-counter instance and a 3-channel/2-bit-counter
// instance. Stimulus pushes expected beats and drop counts into scoreboards; per-instance monitors
// pop and compare whenever a channel hands over a beat or drop_pulse fires.
module tb_demux_stream_generic;

  logic clk;
  logic rst4, rst3;

  demux_stream_generic_if #(.CHANNELS_COUNT(4), .CHANNELS_WIDTH(8), .DROP_COUNT_WIDTH(16)) if4 ();
  demux_stream_generic_if #(.CHANNELS_COUNT(3), .CHANNELS_WIDTH(8), .DROP_COUNT_WIDTH(2))  if3 ();

  demux_stream_generic #(.CHANNELS_COUNT(4), .CHANNELS_WIDTH(8), .DROP_COUNT_WIDTH(16)) dut4 (
    .clk    (clk),
    .rst    (rst4),
    .bus_io (if4)
  );

  demux_stream_generic #(.CHANNELS_COUNT(3), .CHANNELS_WIDTH(8), .DROP_COUNT_WIDTH(2)) dut3 (
    .clk    (clk),
    .rst    (rst3),
    .bus_io (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t       sb4[$];
  exp_t       sb3[$];
  logic [1:0] dq3[$];
  int         drop_model3 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected none at %0t", name, act, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [1:0] s, input logic [7:0] x);
    if (d == 4) begin
      if4.in_valid = v; if4.in_select = s; if4.in_data = x;
    end else begin
      if3.in_valid = v; if3.in_select = s; if3.in_data = x;
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 4) ? if4.in_ready : if3.in_ready;
  endfunction

  // Model: 4-channel instance has every select in range; 3-channel drops select 3
  task automatic push_expected(input int d, input logic [1:0] s, input logic [7:0] x);
    exp_t e;
    e.ch   = int'(s);
    e.data = x;
    if (d == 4) begin
      sb4.push_back(e);
    end else if (s < 2'd3) begin
      sb3.push_back(e);
    end else begin
      drop_model3 = (drop_model3 >= 3) ? 3 : drop_model3 + 1;
      dq3.push_back(drop_model3[1:0]);
    end
  endtask

  // Oldest expected beat of channel ch is the one that must be delivered
  task automatic sb_pop(input int d, input int ch, input logic [7:0] act);
    int idx;
    idx = -1;
    if (d == 4) begin
      for (int j = 0; j < sb4.size(); j++) if (idx < 0 && sb4[j].ch == ch) idx = j;
      if (idx < 0) fail_now($sformatf("dut4_unexpected_beat_ch%0d", ch), act);
      else begin
        check($sformatf("dut4_ch%0d_data", ch), act, sb4[idx].data);
        sb4.delete(idx);
      end
    end else begin
      for (int j = 0; j < sb3.size(); j++) if (idx < 0 && sb3[j].ch == ch) idx = j;
      if (idx < 0) fail_now($sformatf("dut3_unexpected_beat_ch%0d", ch), act);
      else begin
        check($sformatf("dut3_ch%0d_data", ch), act, sb3[idx].data);
        sb3.delete(idx);
      end
    end
  endtask

  // Hold input until accepted (bounded), one ready comparison per beat
  task automatic send(input int d, input logic [1:0] s, input logic [7:0] x, input int max_wait);
    logic r;
    r = 1'b0;
    drive(d, 1'b1, s, x);
    for (int n = 0; n < max_wait; n++) begin
      @(negedge clk);
      r = get_ready(d);
      if (r) break;
      tick();
    end
    check($sformatf("dut%0d_send_ready_sel%0d", d, s), r, 1'b1);
    if (r) begin
      push_expected(d, s, x);
      tick();
    end
    drive(d, 1'b0, 2'd1, 8'h00);
  endtask

  task automatic do_reset3();
    rst3 = 1'b1;
    sb3.delete();
    dq3.delete();
    drop_model3 = 0;
    drive(3, 1'b0, 2'd1, 8'h00);
    @(negedge clk);
    check("dut3_ready_in_reset", if3.in_ready, 1'b0);
    tick();
    rst3 = 1'b0;
    @(negedge clk);
    check("dut3_rst_out_valid", if3.out_valid, 3'b000);
    check("dut3_rst_channels", if3.out_channels, 24'h0);
    check("dut3_rst_drop_count", if3.drop_count, 2'd0);
    check("dut3_rst_drop_pulse", if3.drop_pulse, 1'b0);
    tick();
  endtask

  // Monitor, 4-channel instance
  logic [3:0]      held4;
  logic [3:0][7:0] held4_d;
  always @(negedge clk) begin
    if (rst4) begin
      held4 = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (held4[i]) begin
          check("dut4_hold_valid", if4.out_valid[i], 1'b1);
          check("dut4_hold_data", if4.out_channels[i], held4_d[i]);
        end
        if (if4.out_valid[i] && if4.out_ready[i]) sb_pop(4, i, if4.out_channels[i]);
        else if (!if4.out_valid[i]) check("dut4_idle_zero", if4.out_channels[i], 8'h00);
        held4[i]   = if4.out_valid[i] && !if4.out_ready[i];
        held4_d[i] = if4.out_channels[i];
      end
      if (if4.drop_pulse) fail_now("dut4_unexpected_drop", if4.drop_count);
    end
  end

  // Monitor, 3-channel instance
  logic [2:0]      held3;
  logic [2:0][7:0] held3_d;
  always @(negedge clk) begin
    if (rst3) begin
      held3 = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (held3[i]) begin
          check("dut3_hold_valid", if3.out_valid[i], 1'b1);
          check("dut3_hold_data", if3.out_channels[i], held3_d[i]);
        end
        if (if3.out_valid[i] && if3.out_ready[i]) sb_pop(3, i, if3.out_channels[i]);
        else if (!if3.out_valid[i]) check("dut3_idle_zero", if3.out_channels[i], 8'h00);
        held3[i]   = if3.out_valid[i] && !if3.out_ready[i];
        held3_d[i] = if3.out_channels[i];
      end
      if (if3.drop_pulse) begin
        if (dq3.size() == 0) fail_now("dut3_unexpected_drop", if3.drop_count);
        else check("dut3_drop_count", if3.drop_count, dq3.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    drive(4, 1'b0, 2'd1, 8'h00);
    drive(3, 1'b0, 2'd1, 8'h00);
    if4.out_ready = 4'hF;
    if3.out_ready = 3'h7;
    tick();
    @(negedge clk);
    check("rst_dut4_in_ready", if4.in_ready, 1'b0);
    check("rst_dut3_in_ready", if3.in_ready, 1'b0);
    check("rst_dut4_out_valid", if4.out_valid, 4'h0);
    check("rst_dut4_channels", if4.out_channels, 32'h0);
    check("rst_dut4_drop_pulse", if4.drop_pulse, 1'b0);
    check("rst_dut4_drop_count", if4.drop_count, 16'h0);
    tick();
    rst4 = 1'b0;
    rst3 = 1'b0;
    tick();

    // Basic routing: sel 2 shows on channel 2 only, for one cycle
    send(4, 2'd2, 8'hA5, 4);
    @(negedge clk);
    check("route_out_valid", if4.out_valid, 4'b0100);
    check("route_channels", if4.out_channels, 32'h00A5_0000);
    tick();
    @(negedge clk);
    check("route_drained", if4.out_valid, 4'b0000);
    tick();

    // Backpressure isolation on channel 1
    if4.out_ready = 4'b1101;
    send(4, 2'd1, 8'h11, 4);
    drive(4, 1'b1, 2'd1, 8'h22);
    @(negedge clk);
    check("bp_ready_blocked", if4.in_ready, 1'b0);
    check("bp_ch1_held", if4.out_channels[1], 8'h11);
    tick();
    @(negedge clk);
    check("bp_ready_still_blocked", if4.in_ready, 1'b0);
    tick();
    if4.out_ready = 4'hF;
    push_expected(4, 2'd1, 8'h22);
    @(negedge clk);
    check("bp_ready_released", if4.in_ready, 1'b1);
    tick();
    if4.out_ready = 4'b1101;
    drive(4, 1'b0, 2'd1, 8'h00);
    send(4, 2'd3, 8'h33, 2);
    @(negedge clk);
    check("bp_valid_ch1_ch3", if4.out_valid, 4'b1010);
    check("bp_ch3_data", if4.out_channels[3], 8'h33);
    tick();
    if4.out_ready = 4'hF;
    tick();
    tick();

    // Full throughput on channel 0
    for (int k = 0; k < 8; k++) begin
      drive(4, 1'b1, 2'd0, 8'(k));
      @(negedge clk);
      check("tp_in_ready", if4.in_ready, 1'b1);
      if (k > 0) begin
        check("tp_valid0", if4.out_valid[0], 1'b1);
        check("tp_data0", if4.out_channels[0], 8'(k - 1));
      end
      push_expected(4, 2'd0, 8'(k));
      tick();
    end
    drive(4, 1'b0, 2'd1, 8'h00);
    @(negedge clk);
    check("tp_last_data0", if4.out_channels[0], 8'h07);
    tick();
    @(negedge clk);
    check("tp_idle_after", if4.out_valid[0], 1'b0);
    tick();

    // Out-of-range drop on the 3-channel instance
    send(3, 2'd3, 8'hFF, 1);
    @(negedge clk);
    check("drop_no_valid", if3.out_valid, 3'b000);
    check("drop_pulse_high", if3.drop_pulse, 1'b1);
    check("drop_count_one", if3.drop_count, 2'd1);
    tick();
    @(negedge clk);
    check("drop_pulse_low", if3.drop_pulse, 1'b0);
    tick();
    send(3, 2'd0, 8'h01, 2);
    @(negedge clk);
    check("drop_then_deliver", if3.out_valid, 3'b001);
    tick();
    tick();

    // Counter saturation: 1,2,3,3,3 checked by the monitor
    do_reset3();
    for (int k = 0; k < 5; k++) send(3, 2'd3, 8'(8'hE0 + k), 1);
    tick();
    @(negedge clk);
    check("sat_final_count", if3.drop_count, 2'd3);
    check("sat_pulse_done", if3.drop_pulse, 1'b0);
    tick();

    // Reset mid-operation with stalled beats on channels 0 and 2
    do_reset3();
    if3.out_ready = 3'b000;
    send(3, 2'd0, 8'hC0, 2);
    send(3, 2'd2, 8'hC2, 2);
    send(3, 2'd3, 8'hEE, 2);
    send(3, 2'd3, 8'hEF, 2);
    tick();
    @(negedge clk);
    check("mid_stalled_valid", if3.out_valid, 3'b101);
    check("mid_drop_count", if3.drop_count, 2'd2);
    tick();
    do_reset3();
    if3.out_ready = 3'h7;
    send(3, 2'd2, 8'h5A, 2);
    @(negedge clk);
    check("post_rst_valid", if3.out_valid, 3'b100);
    check("post_rst_channels", if3.out_channels, 24'h5A_0000);
    tick();
    tick();
    tick();

    check("sb4_empty", 64'(sb4.size()), 64'd0);
    check("sb3_empty", 64'(sb3.size()), 64'd0);
    check("dq3_empty", 64'(dq3.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_stream_generic.md
Name: demux_stream_generic

Overview:
- Routes one valid/ready input stream to one of CHANNELS_COUNT output streams, chosen per beat by a select field. It is the inverse of mux_generic.
- Each output channel has a one-entry registered buffer. A stalled channel therefore blocks only beats addressed to it.
- Out-of-range select values are accepted and discarded. Each discard is flagged and counted.
- Sits between a single producer and multiple per-channel consumers.

Parameters:
- CHANNELS_COUNT, 4, number of output channels; must be >= 2 ($fatal at elaboration otherwise).
- CHANNELS_WIDTH, 8, payload width in bits; must be >= 1 ($fatal otherwise).
- DROP_COUNT_WIDTH, 16, width of the saturating drop counter; must be >= 1 ($fatal otherwise).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_select  input  $clog2(CHANNELS_COUNT)  destination channel index of the input beat.
- in_data  input  CHANNELS_WIDTH  input payload.
- out_valid  output  CHANNELS_COUNT  per-channel valid; bit i belongs to channel i.
- out_ready  input  CHANNELS_COUNT  per-channel ready.
- out_channels  output  [CHANNELS_COUNT][CHANNELS_WIDTH]  per-channel payload (packed, same layout as mux_generic channels).
- drop_pulse  output  1  high for one cycle after an out-of-range beat is accepted.
- drop_count  output  DROP_COUNT_WIDTH  number of dropped beats, saturating.

Behaviour:
- Reset, while rst=1 at a clock edge:
  - out_valid=0, out_channels=0, drop_pulse=0, drop_count=0.
  - All buffers are emptied. Beats held in buffers are lost; no partial beat survives.
  - in_ready is low during any cycle in which rst is high.
- Index and range:
  - Compare in_select as an unsigned int against CHANNELS_COUNT.
  - "In range" means sel < CHANNELS_COUNT. This matters when CHANNELS_COUNT is not a power of 2.
- in_ready is combinational:
  - In range: in_ready = !out_valid[sel] || out_ready[sel].
  - Out of range: in_ready = 1.
  - in_ready never depends on other channels' state and never depends on in_valid.
- Accept, in range, on an edge with in_valid && in_ready:
  - Buffer[sel] loads in_data and out_valid[sel] goes to 1.
  - Latency is exactly 1 cycle: the beat appears on out_channels[sel] in the cycle after acceptance.
- Drain: on an edge with out_valid[i] && out_ready[i] and no new accept to channel i, out_valid[i] goes to 0.
- Simultaneous drain and accept on the same channel:
  - The new beat replaces the old one and out_valid[i] stays 1.
  - This gives full throughput of one beat per cycle per channel with no bubble.
- Output stability:
  - While out_valid[i]=1 and out_ready[i]=0, out_channels[i] holds its value.
  - out_valid[i] does not drop in that condition.
- Idle data: when out_valid[i]=0, out_channels[i] is driven '0.
- Out-of-range accept:
  - The beat is discarded and no out_valid bit changes.
  - Next cycle drop_pulse=1.
  - drop_count increments by 1 and saturates at 2^DROP_COUNT_WIDTH-1 (no wrap).
- No accept: in_valid=0 leaves all buffers and the counter unchanged; drop_pulse=0.
- Independence: channels drain independently and in parallel. Any combination of out_ready bits is legal in any cycle.
- Ordering: beats to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- X handling: in_select and in_data are don't-care while in_valid=0.

Test Plan:
- Reset and basic routing: reset with CHANNELS_COUNT=4, WIDTH=8, all out_ready=1. Send sel=2, data=0xA5 → in the next cycle out_valid=4'b0100, out_channels[2]=0xA5, all other channels 0. In the cycle after that, out_valid=0.
- Backpressure isolation: hold out_ready[1]=0. Send sel=1,0x11, then sel=1,0x22, then sel=3,0x33 →
  - 0x11 is held on channel 1.
  - in_ready=0 while 0x22 is presented, and 0x22 is not accepted.
  - When out_ready[1] rises, 0x11 drains and 0x22 is accepted in the same cycle.
  - 0x33 reaches channel 3 unaffected by channel 1.
- Full throughput: out_ready[0]=1, send 8 back-to-back beats 0x00..0x07 to sel=0 → in_ready stays 1 throughout. Channel 0 shows 0x00..0x07 on consecutive cycles with out_valid[0] continuously 1.
- Out-of-range drop: CHANNELS_COUNT=3, send sel=3, data=0xFF →
  - in_ready=1 and no out_valid bit rises.
  - drop_pulse=1 for exactly one cycle and drop_count=1.
  - A following beat sel=0,0x01 is delivered normally.
- Counter saturation: DROP_COUNT_WIDTH=2, send 5 out-of-range beats → drop_count reads 1,2,3,3,3. drop_pulse fires every time.
- Reset mid-operation: with channels 0 and 2 holding stalled beats and drop_count=2, assert rst for 1 cycle →
  - out_valid=0, out_channels=0, drop_count=0, in_ready=0 during reset.
  - After reset, a beat sel=2,0x5A arrives alone on channel 2.
